// File: rtl/hdb3_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : hdb3_encoder
//  Description : Serial HDB3 line encoder. Accepts one NRZ bit per enabled
//                clock and emits the dual-rail HDB3 symbol stream, replacing
//                each run of four zeros with 000V or B00V while keeping
//                alternate-mark polarity.
//  Ports       : i_clk    - clock, all logic on the rising edge
//                i_rst_n  - synchronous active-low reset
//                i_en     - bit strobe; pipeline advances only when high
//                i_data   - NRZ input bit
//                o_pos    - positive-rail pulse of the current symbol
//                o_neg    - negative-rail pulse of the current symbol
//                o_valid  - one-cycle strobe per emitted symbol
//                o_v      - current symbol is a violation pulse
//                o_b      - current symbol is a balancing pulse
//  Revision    : 1.0 - initial release
// ============================================================================
module hdb3_encoder #(
    parameter logic INIT_POL = 1'b0  // 0: notional last pulse was negative
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_en,
    input  logic i_data,
    output logic o_pos,
    output logic o_neg,
    output logic o_valid,
    output logic o_v,
    output logic o_b
);

    // Symbol codes held in the four-stage look-ahead buffer
    localparam logic [1:0] c_SYM_ZERO = 2'd0;
    localparam logic [1:0] c_SYM_ONE  = 2'd1;
    localparam logic [1:0] c_SYM_B    = 2'd2;
    localparam logic [1:0] c_SYM_V    = 2'd3;

    localparam logic [2:0] c_FILL_FULL = 3'd4;

    logic [1:0] r_s0;
    logic [1:0] r_s1;
    logic [1:0] r_s2;
    logic [1:0] r_s3;
    logic [1:0] r_zcnt;      // consecutive real input zeros, 0..3
    logic       r_par;       // parity of marks entered since the last V
    logic       r_lastpol;   // polarity of last emitted pulse (1 = positive)
    logic [2:0] r_fill;      // accepted bits, saturating at 4

    logic [1:0] w_s0_next;
    logic [1:0] w_zcnt_next;
    logic       w_par_next;
    logic       w_b_insert;

    logic       w_mark;
    logic       w_viol;
    logic       w_pol;
    logic       w_lastpol_next;
    logic       w_fill_full;

    // Input classification. When the fourth zero arrives the V enters s0 and,
    // on an even mark count, the first zero of the run (currently in s2) is
    // rewritten to B on its way into s3, so B always leads V by three slots.
    always_comb begin
        w_s0_next   = c_SYM_ZERO;
        w_zcnt_next = r_zcnt;
        w_par_next  = r_par;
        w_b_insert  = 1'b0;
        if (i_data) begin
            w_s0_next   = c_SYM_ONE;
            w_zcnt_next = 2'd0;
            w_par_next  = ~r_par;
        end else if (r_zcnt == 2'd3) begin
            w_s0_next   = c_SYM_V;
            w_zcnt_next = 2'd0;
            w_par_next  = 1'b0;
            w_b_insert  = ~r_par;
        end else begin
            w_s0_next   = c_SYM_ZERO;
            w_zcnt_next = r_zcnt + 2'd1;
        end
    end

    // Output decode from the oldest buffered symbol. Marks (ONE and B)
    // alternate polarity; V deliberately repeats the previous polarity.
    always_comb begin
        w_mark         = (r_s3 == c_SYM_ONE) || (r_s3 == c_SYM_B);
        w_viol         = (r_s3 == c_SYM_V);
        w_pol          = w_viol ? r_lastpol : ~r_lastpol;
        w_lastpol_next = w_mark ? ~r_lastpol : r_lastpol;
        w_fill_full    = (r_fill == c_FILL_FULL);
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_s0      <= c_SYM_ZERO;
            r_s1      <= c_SYM_ZERO;
            r_s2      <= c_SYM_ZERO;
            r_s3      <= c_SYM_ZERO;
            r_zcnt    <= 2'd0;
            r_par     <= 1'b0;
            r_lastpol <= INIT_POL;
            r_fill    <= 3'd0;
            o_pos     <= 1'b0;
            o_neg     <= 1'b0;
            o_valid   <= 1'b0;
            o_v       <= 1'b0;
            o_b       <= 1'b0;
        end else begin
            o_valid <= 1'b0;
            if (i_en) begin
                r_s0   <= w_s0_next;
                r_s1   <= r_s0;
                r_s2   <= r_s1;
                r_s3   <= w_b_insert ? c_SYM_B : r_s2;
                r_zcnt <= w_zcnt_next;
                r_par  <= w_par_next;
                if (!w_fill_full) begin
                    r_fill <= r_fill + 3'd1;
                end
                // Until four real bits are buffered s3 only holds reset
                // filler, which must never reach the line.
                if (w_fill_full) begin
                    o_pos     <= (w_mark || w_viol) && w_pol;
                    o_neg     <= (w_mark || w_viol) && !w_pol;
                    o_v       <= w_viol;
                    o_b       <= (r_s3 == c_SYM_B);
                    o_valid   <= 1'b1;
                    r_lastpol <= w_lastpol_next;
                end else begin
                    o_pos <= 1'b0;
                    o_neg <= 1'b0;
                    o_v   <= 1'b0;
                    o_b   <= 1'b0;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hdb3_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hdb3_encoder
//  Description : Self-checking bench for hdb3_encoder. A reference encoder
//                builds the expected symbol for every input bit; symbols are
//                queued as bits are driven and popped when o_valid appears.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hdb3_encoder;

    localparam logic INIT_POL = 1'b0;

    typedef logic [3:0] sym_t;  // {pos, neg, v, b}

    logic clk = 1'b0;
    logic rst_n;
    logic en;
    logic data;
    logic o_pos;
    logic o_neg;
    logic o_valid;
    logic o_v;
    logic o_b;

    always #5 clk = ~clk;

    hdb3_encoder #(.INIT_POL(INIT_POL)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_en    (en),
        .i_data  (data),
        .o_pos   (o_pos),
        .o_neg   (o_neg),
        .o_valid (o_valid),
        .o_v     (o_v),
        .o_b     (o_b)
    );

    sym_t exp_q[$];
    sym_t emitted[$];
    sym_t ref_run[$];
    logic bits[0:511];
    sym_t exp_syms[0:511];
    int   errors = 0;
    int   checks = 0;
    bit   mon_on = 1'b0;
    int   fill_tb = 0;
    sym_t prev_out = 4'b0000;

    // Reference encoder working over the whole stream: on the fourth zero it
    // goes back and rewrites the first zero of the run as B when needed.
    function automatic void build_model(input int n);
        logic lp;
        logic par;
        int   zr;
        lp  = INIT_POL;
        par = 1'b0;
        zr  = 0;
        for (int i = 0; i < n; i++) begin
            if (bits[i]) begin
                lp          = ~lp;
                exp_syms[i] = {lp, ~lp, 2'b00};
                par         = ~par;
                zr          = 0;
            end else begin
                exp_syms[i] = 4'b0000;
                zr++;
                if (zr == 4) begin
                    if (!par) begin
                        lp              = ~lp;
                        exp_syms[i - 3] = {lp, ~lp, 2'b01};
                    end
                    exp_syms[i] = {lp, ~lp, 2'b10};
                    par         = 1'b0;
                    zr          = 0;
                end
            end
        end
    endfunction

    // Scoreboard / protocol monitor, sampling 1 time unit after each edge
    always @(posedge clk) begin
        logic e;
        logic r;
        int   f;
        sym_t got;
        sym_t want;
        e = en;
        r = rst_n;
        f = fill_tb;
        if (!r) fill_tb = 0;
        else if (e && fill_tb < 4) fill_tb++;
        #1;
        got = {o_pos, o_neg, o_v, o_b};
        if (mon_on) begin
            checks++;
            if (o_valid !== (r && e && f >= 4)) begin
                errors++;
                $display("FAIL valid_timing: o_valid=%b expected %b at %0t", o_valid, (r && e && f >= 4), $time);
            end
            checks++;
            if ((o_pos & o_neg) !== 1'b0) begin
                errors++;
                $display("FAIL both_rails: pos=%b neg=%b expected not both 1 at %0t", o_pos, o_neg, $time);
            end
            if (!r) begin
                checks++;
                if ({got, o_valid} !== 5'b00000) begin
                    errors++;
                    $display("FAIL reset_outputs: got %b expected 00000 at %0t", {got, o_valid}, $time);
                end
            end else if (!e) begin
                checks++;
                if (got !== prev_out) begin
                    errors++;
                    $display("FAIL hold: got %b expected %b at %0t", got, prev_out, $time);
                end
            end
            if (o_valid === 1'b1) begin
                emitted.push_back(got);
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL scoreboard_underflow: got %b expected no symbol at %0t", got, $time);
                end else begin
                    want = exp_q.pop_front();
                    if (got !== want) begin
                        errors++;
                        $display("FAIL symbol: got %b expected %b at %0t", got, want, $time);
                    end
                end
            end
        end
        prev_out = got;
    end

    task automatic drive(input logic e, input logic d, input int idx);
        en   = e;
        data = d;
        if (e) exp_q.push_back(exp_syms[idx]);
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        en    = 1'b0;
        data  = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        emitted.delete();
    endtask

    task automatic run_stream(input int n, input bit rand_en);
        int i;
        i = 0;
        while (i < n) begin
            if (rand_en && $urandom_range(1, 0) == 0) begin
                drive(1'b0, 1'($urandom_range(1, 0)), 0);
            end else begin
                drive(1'b1, bits[i], i);
                i++;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        en    = 1'b1;
        data  = 1'b1;
        @(posedge clk);
        #2;
        mon_on = 1'b1;
        @(posedge clk);
        #2;
        checks++;
        if ({o_pos, o_neg, o_valid, o_v, o_b} !== 5'b00000) begin
            errors++;
            $display("FAIL reset_state: got %b expected 00000", {o_pos, o_neg, o_valid, o_v, o_b});
        end
        rst_n = 1'b1;
        en    = 1'b0;
    endtask

    task automatic test_all_zeros();
        sym_t tbl[8];
        int   first;
        tbl = '{4'b1001, 4'b0000, 4'b0000, 4'b1010, 4'b0101, 4'b0000, 4'b0000, 4'b0110};
        do_reset();
        for (int i = 0; i < 20; i++) bits[i] = (i >= 16);
        build_model(20);
        first = -1;
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, bits[i], i);
            if (o_valid === 1'b1 && first < 0) first = i + 1;
        end
        checks++;
        if (first != 5) begin
            errors++;
            $display("FAIL first_valid: got accepted-edge %0d expected 5", first);
        end
        checks++;
        if (emitted.size() != 16) begin
            errors++;
            $display("FAIL zeros_count: got %0d expected 16", emitted.size());
        end else begin
            for (int i = 0; i < 16; i++) begin
                checks++;
                if (emitted[i] !== tbl[i % 8]) begin
                    errors++;
                    $display("FAIL zeros_pattern[%0d]: got %b expected %b", i, emitted[i], tbl[i % 8]);
                end
            end
        end
    endtask

    task automatic test_single_mark();
        sym_t tbl[9];
        tbl = '{4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b1010, 4'b0101, 4'b0000, 4'b0000, 4'b0110};
        do_reset();
        for (int i = 0; i < 13; i++) bits[i] = (i == 0) || (i >= 9);
        build_model(13);
        run_stream(13, 1'b0);
        checks++;
        if (emitted.size() != 9) begin
            errors++;
            $display("FAIL mark_count: got %0d expected 9", emitted.size());
        end else begin
            for (int i = 0; i < 9; i++) begin
                checks++;
                if (emitted[i] !== tbl[i]) begin
                    errors++;
                    $display("FAIL mark_pattern[%0d]: got %b expected %b", i, emitted[i], tbl[i]);
                end
            end
        end
    endtask

    task automatic test_even_parity();
        sym_t tbl[6];
        tbl = '{4'b1000, 4'b0100, 4'b1001, 4'b0000, 4'b0000, 4'b1010};
        do_reset();
        for (int i = 0; i < 10; i++) bits[i] = (i < 2) || (i >= 6);
        build_model(10);
        run_stream(10, 1'b0);
        checks++;
        if (emitted.size() != 6) begin
            errors++;
            $display("FAIL even_count: got %0d expected 6", emitted.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                checks++;
                if (emitted[i] !== tbl[i]) begin
                    errors++;
                    $display("FAIL even_pattern[%0d]: got %b expected %b", i, emitted[i], tbl[i]);
                end
            end
        end
    endtask

    task automatic load_pattern();
        logic [31:0] pat;
        pat = 32'h8900_F080;
        for (int i = 0; i < 256; i++) bits[i] = pat[31 - (i % 32)];
        build_model(256);
    endtask

    task automatic test_pattern();
        int zrun;
        int zbad;
        int vbad;
        int disp;
        int dmax;
        int lastv;
        do_reset();
        load_pattern();
        run_stream(256, 1'b0);
        ref_run = emitted;
        zrun  = 0;
        zbad  = 0;
        vbad  = 0;
        disp  = 0;
        dmax  = 0;
        lastv = 0;
        foreach (emitted[i]) begin
            if (emitted[i][3:2] == 2'b00) zrun++;
            else zrun = 0;
            if (zrun >= 4) zbad++;
            if (emitted[i][3]) disp++;
            if (emitted[i][2]) disp--;
            if (disp > dmax) dmax = disp;
            if (-disp > dmax) dmax = -disp;
            if (emitted[i][1]) begin
                if ((emitted[i][3] ? 1 : -1) == lastv) vbad++;
                lastv = emitted[i][3] ? 1 : -1;
            end
        end
        checks++;
        if (emitted.size() != 252) begin
            errors++;
            $display("FAIL pattern_count: got %0d expected 252", emitted.size());
        end
        checks++;
        if (zbad != 0) begin
            errors++;
            $display("FAIL zero_run: got %0d runs of 4 zeros expected 0", zbad);
        end
        checks++;
        if (vbad != 0) begin
            errors++;
            $display("FAIL v_alternation: got %0d repeated V polarities expected 0", vbad);
        end
        checks++;
        if (dmax > 2) begin
            errors++;
            $display("FAIL disparity: got peak %0d expected at most 2", dmax);
        end
    endtask

    task automatic test_random_en();
        int diff;
        do_reset();
        load_pattern();
        run_stream(256, 1'b1);
        checks++;
        if (emitted.size() != ref_run.size()) begin
            errors++;
            $display("FAIL random_en_count: got %0d expected %0d", emitted.size(), ref_run.size());
        end else begin
            diff = 0;
            foreach (emitted[i]) if (emitted[i] !== ref_run[i]) diff++;
            checks++;
            if (diff != 0) begin
                errors++;
                $display("FAIL random_en_stream: got %0d differing symbols expected 0", diff);
            end
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        for (int i = 0; i < 9; i++) bits[i] = (i < 6);
        build_model(9);
        run_stream(9, 1'b0);
        rst_n = 1'b0;
        en    = 1'b1;
        data  = 1'b0;
        exp_q.delete();
        @(posedge clk);
        #2;
        checks++;
        if ({o_pos, o_neg, o_valid, o_v, o_b} !== 5'b00000) begin
            errors++;
            $display("FAIL mid_reset_outputs: got %b expected 00000", {o_pos, o_neg, o_valid, o_v, o_b});
        end
        rst_n = 1'b1;
        emitted.delete();
        for (int i = 0; i < 10; i++) bits[i] = (i < 2) || (i >= 6);
        build_model(10);
        run_stream(10, 1'b0);
        checks++;
        if (emitted.size() != 6) begin
            errors++;
            $display("FAIL restart_count: got %0d expected 6", emitted.size());
        end else begin
            checks++;
            if (emitted[0] !== 4'b1000) begin
                errors++;
                $display("FAIL restart_first: got %b expected 1000", emitted[0]);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        en    = 1'b0;
        data  = 1'b0;
        test_reset();
        test_all_zeros();
        test_single_mark();
        test_even_parity();
        test_pattern();
        test_random_en();
        test_mid_reset();
        en = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire
